scmi_mbox_multichan: RTL and testbench
======================================

# scmi_mbox_multichan

Parametrised multi-channel SCMI mailbox. It is a register-bus slave that sits behind the team's existing AXI data-width converter and axi-to-reg bridge. It provides NumChannels independent channels, each with a shared-memory payload area, a channel-free flag, a doorbell (agent→platform) and a completion (platform→agent) notification. It generalises the single-channel mailbox with per-channel interrupt enables, selectable level/pulse interrupt mode, a per-channel doorbell counter and address-range error reporting.

## Interface
- NumChannels, default 4: number of independent channels, 1..32.
- ShmemWords, default 32: 32-bit payload words per channel, ≥1.
- AddrWidth, default 64: register-bus address width.
- IrqPulse, default 0: 0 means interrupts are level; 1 means interrupts are one-cycle pulses.
- reg_req_t, default logic: register-bus request type (addr, write, wdata[31:0], wstrb[3:0], valid).
- reg_rsp_t, default logic: register-bus response type (rdata[31:0], error, ready).
- clk_i  in  1  clock; the block uses one clock.
- rst_ni  in  1  reset; synchronous, active-low.
- reg_req_i  in  reg_req_t  register-bus request.
- reg_rsp_o  out  reg_rsp_t  register-bus response.
- doorbell_irq_o  out  NumChannels  per-channel interrupt towards the platform.
- completion_irq_o  out  NumChannels  per-channel interrupt towards the agent.

## Operation
- Address decode:
  - ChanAw = $clog2(ShmemWords+4); channel stride is 4·2^ChanAw bytes.
  - Word offset = addr[ChanAw+1:2].
  - Channel index = the next $clog2(NumChannels) bits above the word offset (at least 1 bit).
  - Higher address bits and addr[1:0] are ignored.
- Per-channel word map:
  - Offset 0, STATUS: bit0 free (read-only, reset 1); bit1 error (write 1 to clear, set by hardware only on an out-of-range access to this channel's payload range); other bits read 0.
  - Offset 1, FLAGS: bit0 db_irq_en, bit1 cmpl_irq_en; both reset 0 and are read/write.
  - Offset 2, DOORBELL: bit0 pending; bits[31:16] db_count.
  - Offset 3, COMPLETION: bit0 pending.
  - Offsets 4..ShmemWords+3: payload words, read/write, reset 0, honouring wstrb per byte.
- DOORBELL write with wstrb[0]=1:
  - wdata[0]=1 sets db_pending, clears free, and increments db_count (16-bit, wraps 0xFFFF→0x0000).
  - wdata[0]=0 clears db_pending (platform acknowledge).
- COMPLETION write with wstrb[0]=1:
  - wdata[0]=1 sets cmpl_pending and sets free.
  - wdata[0]=0 clears cmpl_pending.
- Writes to control words with wstrb[0]=0 have no effect. Writes to STATUS bit0 are ignored.
- Error response:
  - Raised when channel index ≥ NumChannels or word offset ≥ ShmemWords+4.
  - An error access has no side effect and returns rdata=0.
  - It sets STATUS.error of the decoded channel only if that channel index is valid.
- Interrupts, level mode (IrqPulse=0):
  - doorbell_irq_o[c] is a register equal to db_pending[c]&db_irq_en[c].
  - completion_irq_o[c] is the same, using cmpl_pending[c]&cmpl_irq_en[c].
- Interrupts, pulse mode (IrqPulse=1):
  - The output is a one-cycle pulse registered from the rising edge of (pending&en).
  - Re-writing 1 to an already-set pending bit produces no new pulse.
  - Enabling while already pending produces a pulse.
- Reset values:
  - All irq outputs 0.
  - reg_rsp_o.ready mirrors valid combinationally; rdata and error are 0 when valid=0.
  - All pending bits 0, free 1, enables 0, counters 0, payload 0.

## Timing
- Register bus:
  - Zero-wait-state: ready=valid in the same cycle.
  - rdata and error are combinational from the current state and address.
  - Write state updates at the clock edge where valid&write.
- A read in the cycle after a write returns the new value.
- Interrupt latency: the irq output changes exactly one cycle after the write edge that changes pending or enable (registered output).
- Pulse mode:
  - The pulse lasts exactly one cycle.
  - Set-then-clear of pending on consecutive cycles still yields one pulse.
- Synchronous reset mid-transfer:
  - The reset state is reached at the next edge with rst_ni=0.
  - A write presented in that cycle is discarded.
  - Irq outputs are 0 from the following cycle.
- Channels are fully independent; one access per cycle, so no intra-register set/clear collision exists.

## Test plan
- **Reset:** after reset, read ch0 STATUS → 0x1; FLAGS → 0x0; DOORBELL → 0x0; all irq outputs 0.
- **Doorbell, level mode** (NumChannels=4): write ch2 FLAGS=0x1, then ch2 DOORBELL=0x1 → doorbell_irq_o=4'b0100 one cycle later; ch2 STATUS → 0x0; ch2 DOORBELL → 0x0001_0001. Write 0 → irq low the next cycle.
- **Pulse mode:**
  - Enable cmpl on ch1, write COMPLETION=1 twice → exactly one single-cycle pulse on completion_irq_o[1]; STATUS.free=1.
  - Clear, then set again → a second pulse.
- **Counter wrap:** 65536 doorbell writes of 1 on ch0 → db_count reads 0x0000; pending still 1.
- **Out-of-range:** access channel index 4 with NumChannels=4 → error=1, rdata=0, no state change. Access ch0 at offset ShmemWords+4 (when within 2^ChanAw) → error=1 and ch0 STATUS bit1=1. Write STATUS=0x2 → bit1 cleared.
- **Payload:** write ch3 payload word 0 = 0xA5A5A5A5 with wstrb=4'b0101 over a zero word → read 0x00A500A5; assert rst_ni=0 for one cycle during a write → read 0 afterwards.

Source files
------------

// File: rtl/scmi_mbox_multichan.sv
// Multi-channel SCMI mailbox: per-channel shared memory, free flag, doorbell and
// completion notifications behind a zero-wait-state register bus.
package scmi_mbox_multichan_pkg;
  typedef struct packed {
    logic [63:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        valid;
  } reg_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
    logic        ready;
  } reg_rsp_t;
endpackage

module scmi_mbox_multichan #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned ShmemWords  = 32,
  parameter int unsigned AddrWidth   = 64,
  parameter bit          IrqPulse    = 1'b0,
  parameter type         reg_req_t   = scmi_mbox_multichan_pkg::reg_req_t,
  parameter type         reg_rsp_t   = scmi_mbox_multichan_pkg::reg_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  reg_req_t               reg_req_i,
  output reg_rsp_t               reg_rsp_o,
  output logic [NumChannels-1:0] doorbell_irq_o,
  output logic [NumChannels-1:0] completion_irq_o
);

  localparam int unsigned ChanAw  = $clog2(ShmemWords + 4);
  localparam int unsigned ChBits  = (NumChannels > 1) ? $clog2(NumChannels) : 1;
  localparam int unsigned PayBits = (ShmemWords > 1) ? $clog2(ShmemWords) : 1;

  logic [AddrWidth-1:0] addr;
  logic [ChanAw-1:0]    word_off;
  logic [ChBits-1:0]    ch_idx;
  logic [PayBits-1:0]   pay_idx;
  logic                 ch_ok, off_ok, acc_err, is_payload, wr_en;
  logic [31:0]          rdata;
  logic                 unused_addr;

  logic [NumChannels-1:0] free_q, err_q, db_en_q, cm_en_q, db_pend_q, cm_pend_q;
  logic [NumChannels-1:0] db_lvl_q, cm_lvl_q;
  logic [15:0]            db_cnt_q [NumChannels];
  logic [31:0]            shmem_q  [NumChannels][ShmemWords];

  assign addr        = reg_req_i.addr;
  assign word_off    = addr[ChanAw+1:2];
  assign ch_idx      = addr[ChanAw+ChBits+1:ChanAw+2];
  assign unused_addr = ^{addr[AddrWidth-1:ChanAw+ChBits+2], addr[1:0]};

  assign ch_ok      = 32'(ch_idx) < NumChannels;
  assign off_ok     = 32'(word_off) < ShmemWords + 4;
  assign acc_err    = !(ch_ok && off_ok);
  assign is_payload = word_off >= ChanAw'(4);
  assign pay_idx    = PayBits'(word_off - ChanAw'(4));
  assign wr_en      = reg_req_i.valid && reg_req_i.write && !acc_err;

  // Combinational read path; error accesses and idle cycles return zero data.
  always_comb begin
    rdata = '0;
    if (reg_req_i.valid && !acc_err) begin
      if (is_payload) begin
        rdata = shmem_q[ch_idx][pay_idx];
      end else begin
        case (word_off[1:0])
          2'd0: rdata = {30'b0, err_q[ch_idx], free_q[ch_idx]};
          2'd1: rdata = {30'b0, cm_en_q[ch_idx], db_en_q[ch_idx]};
          2'd2: rdata = {db_cnt_q[ch_idx], 15'b0, db_pend_q[ch_idx]};
          2'd3: rdata = {31'b0, cm_pend_q[ch_idx]};
        endcase
      end
    end
  end

  always_comb begin
    reg_rsp_o       = '0;
    reg_rsp_o.ready = reg_req_i.valid;
    reg_rsp_o.error = reg_req_i.valid && acc_err;
    reg_rsp_o.rdata = rdata;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      free_q    <= '1;
      err_q     <= '0;
      db_en_q   <= '0;
      cm_en_q   <= '0;
      db_pend_q <= '0;
      cm_pend_q <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        db_cnt_q[c] <= '0;
        for (int w = 0; w < ShmemWords; w++) shmem_q[c][w] <= '0;
      end
    end else begin
      // Only a valid channel can latch an out-of-range payload error.
      if (reg_req_i.valid && ch_ok && !off_ok) err_q[ch_idx] <= 1'b1;
      if (wr_en) begin
        if (is_payload) begin
          for (int b = 0; b < 4; b++) begin
            if (reg_req_i.wstrb[b]) shmem_q[ch_idx][pay_idx][8*b +: 8] <= reg_req_i.wdata[8*b +: 8];
          end
        end else if (reg_req_i.wstrb[0]) begin
          case (word_off[1:0])
            2'd0: if (reg_req_i.wdata[1]) err_q[ch_idx] <= 1'b0;
            2'd1: begin
              db_en_q[ch_idx] <= reg_req_i.wdata[0];
              cm_en_q[ch_idx] <= reg_req_i.wdata[1];
            end
            2'd2: begin
              if (reg_req_i.wdata[0]) begin
                db_pend_q[ch_idx] <= 1'b1;
                free_q[ch_idx]    <= 1'b0;
                db_cnt_q[ch_idx]  <= db_cnt_q[ch_idx] + 16'd1;
              end else begin
                db_pend_q[ch_idx] <= 1'b0;
              end
            end
            2'd3: begin
              if (reg_req_i.wdata[0]) begin
                cm_pend_q[ch_idx] <= 1'b1;
                free_q[ch_idx]    <= 1'b1;
              end else begin
                cm_pend_q[ch_idx] <= 1'b0;
              end
            end
          endcase
        end
      end
    end
  end

  // Registered interrupt level; in pulse mode it doubles as the edge-detect history.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      db_lvl_q <= '0;
      cm_lvl_q <= '0;
    end else begin
      db_lvl_q <= db_pend_q & db_en_q;
      cm_lvl_q <= cm_pend_q & cm_en_q;
    end
  end

  if (IrqPulse) begin : g_pulse
    logic [NumChannels-1:0] db_pulse_q, cm_pulse_q;
    always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
        db_pulse_q <= '0;
        cm_pulse_q <= '0;
      end else begin
        db_pulse_q <= (db_pend_q & db_en_q) & ~db_lvl_q;
        cm_pulse_q <= (cm_pend_q & cm_en_q) & ~cm_lvl_q;
      end
    end
    assign doorbell_irq_o   = db_pulse_q;
    assign completion_irq_o = cm_pulse_q;
  end else begin : g_level
    assign doorbell_irq_o   = db_lvl_q;
    assign completion_irq_o = cm_lvl_q;
  end

endmodule

// File: tb/tb_scmi_mbox_multichan.sv
// Bench for scmi_mbox_multichan: level and pulse instances share one bus and are
// compared every cycle against a behavioural mailbox model.
module tb_scmi_mbox_multichan;
  import scmi_mbox_multichan_pkg::*;

  localparam int NCH = 4;
  localparam int SHM = 32;
  localparam int CAW = 6;
  localparam int CHB = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  reg_req_t       req;
  reg_rsp_t       rsp_l, rsp_p;
  logic [NCH-1:0] db_l, cm_l, db_p, cm_p;

  always #5 clk = ~clk;

  scmi_mbox_multichan #(.NumChannels(NCH), .ShmemWords(SHM), .AddrWidth(64), .IrqPulse(1'b0)) u_lvl (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp_l),
    .doorbell_irq_o(db_l), .completion_irq_o(cm_l));

  scmi_mbox_multichan #(.NumChannels(NCH), .ShmemWords(SHM), .AddrWidth(64), .IrqPulse(1'b1)) u_pls (
    .clk_i(clk), .rst_ni(rst_n), .reg_req_i(req), .reg_rsp_o(rsp_p),
    .doorbell_irq_o(db_p), .completion_irq_o(cm_p));

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  bit          m_free [NCH];
  bit          m_err  [NCH];
  bit          m_dben [NCH];
  bit          m_cmen [NCH];
  bit          m_dbp  [NCH];
  bit          m_cmp  [NCH];
  int          m_cnt  [NCH];
  logic [31:0] m_pay  [NCH][SHM];
  logic [NCH-1:0] exp_db_lvl, exp_cm_lvl, exp_db_pls, exp_cm_pls;
  logic [33:0]    e_rsp;

  task automatic check_output(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] mk(input int ch, input int off);
    return (64'(ch) << (CAW + 2)) | (64'(off) << 2);
  endfunction

  // Returns {rdata, error, ready} as the bus must present it for this access.
  function automatic logic [33:0] model_rsp(input logic valid, input logic [63:0] a);
    int ch, off;
    logic [31:0] d;
    ch  = int'((a >> (CAW + 2)) % (64'd1 << CHB));
    off = int'((a >> 2) % (64'd1 << CAW));
    if (!valid) return 34'b0;
    if (ch >= NCH || off >= SHM + 4) return {32'b0, 1'b1, 1'b1};
    case (off)
      0:       d = 32'(m_err[ch]) * 2 + 32'(m_free[ch]);
      1:       d = 32'(m_cmen[ch]) * 2 + 32'(m_dben[ch]);
      2:       d = 32'(m_cnt[ch]) * 65536 + 32'(m_dbp[ch]);
      3:       d = 32'(m_cmp[ch]);
      default: d = m_pay[ch][off-4];
    endcase
    return {d, 1'b0, 1'b1};
  endfunction

  // Advances the model by one clock edge for the access presented in that cycle.
  function automatic void model_step(input logic rst, input reg_req_t r);
    logic [NCH-1:0] l_db, l_cm;
    int ch, off;
    for (int c = 0; c < NCH; c++) begin
      l_db[c] = m_dbp[c] & m_dben[c];
      l_cm[c] = m_cmp[c] & m_cmen[c];
    end
    if (!rst) begin
      exp_db_lvl = '0; exp_cm_lvl = '0; exp_db_pls = '0; exp_cm_pls = '0;
      for (int c = 0; c < NCH; c++) begin
        m_free[c] = 1; m_err[c] = 0; m_dben[c] = 0; m_cmen[c] = 0;
        m_dbp[c] = 0; m_cmp[c] = 0; m_cnt[c] = 0;
        for (int w = 0; w < SHM; w++) m_pay[c][w] = 32'h0;
      end
      return;
    end
    exp_db_pls = l_db & ~exp_db_lvl;
    exp_cm_pls = l_cm & ~exp_cm_lvl;
    exp_db_lvl = l_db;
    exp_cm_lvl = l_cm;
    if (!r.valid) return;
    ch  = int'((r.addr >> (CAW + 2)) % (64'd1 << CHB));
    off = int'((r.addr >> 2) % (64'd1 << CAW));
    if (ch >= NCH) return;
    if (off >= SHM + 4) begin
      m_err[ch] = 1;
      return;
    end
    if (!r.write) return;
    if (off >= 4) begin
      for (int b = 0; b < 4; b++)
        if (r.wstrb[b]) m_pay[ch][off-4][8*b +: 8] = r.wdata[8*b +: 8];
    end else if (r.wstrb[0]) begin
      case (off)
        0: if (r.wdata[1]) m_err[ch] = 0;
        1: begin m_dben[ch] = r.wdata[0]; m_cmen[ch] = r.wdata[1]; end
        2: if (r.wdata[0]) begin
             m_dbp[ch] = 1; m_free[ch] = 0; m_cnt[ch] = (m_cnt[ch] + 1) % 65536;
           end else m_dbp[ch] = 0;
        default: if (r.wdata[0]) begin
             m_cmp[ch] = 1; m_free[ch] = 1;
           end else m_cmp[ch] = 0;
      endcase
    end
  endfunction

  task automatic apply_stimulus(input logic rst, input logic valid, input logic wr,
                                input logic [63:0] a, input logic [31:0] wd, input logic [3:0] ws);
    rst_n = rst; req.valid = valid; req.write = wr; req.addr = a; req.wdata = wd; req.wstrb = ws;
    @(posedge clk);
    model_step(rst, req);
    #1;
  endtask

  task automatic do_read(input string nm, input logic [63:0] a, input logic [31:0] exp_d, input logic exp_e);
    rst_n = 1'b1; req.valid = 1'b1; req.write = 1'b0; req.addr = a; req.wdata = '0; req.wstrb = '0;
    @(negedge clk);
    check_output(nm, 64'({rsp_l.error, rsp_l.rdata}), 64'({exp_e, exp_d}));
    @(posedge clk);
    model_step(1'b1, req);
    #1;
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      e_rsp = model_rsp(req.valid, req.addr);
      check_output("rsp_level", 64'(rsp_l), 64'(e_rsp));
      check_output("rsp_pulse", 64'(rsp_p), 64'(e_rsp));
      check_output("db_irq_level", 64'(db_l), 64'(exp_db_lvl));
      check_output("cm_irq_level", 64'(cm_l), 64'(exp_cm_lvl));
      check_output("db_irq_pulse", 64'(db_p), 64'(exp_db_pls));
      check_output("cm_irq_pulse", 64'(cm_p), 64'(exp_cm_pls));
    end
  end

  int          ch, off, r;
  logic [63:0] a;
  logic [3:0]  ws;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
    cmp_en = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 64'h0, 32'h0, 4'h0);

    do_read("reset_status", mk(0, 0), 32'h1, 1'b0);
    do_read("reset_flags", mk(0, 1), 32'h0, 1'b0);
    do_read("reset_doorbell", mk(0, 2), 32'h0, 1'b0);
    check_output("reset_irqs", 64'({db_l, cm_l, db_p, cm_p}), 64'h0);

    apply_stimulus(1'b1, 1'b1, 1'b1, mk(2, 1), 32'h1, 4'hF);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(2, 2), 32'h1, 4'hF);
    do_read("ch2_status_busy", mk(2, 0), 32'h0, 1'b0);
    check_output("db_level_ch2", 64'(db_l), 64'h4);
    check_output("db_pulse_ch2", 64'(db_p), 64'h4);
    do_read("ch2_doorbell", mk(2, 2), 32'h0001_0001, 1'b0);
    check_output("db_pulse_ch2_end", 64'(db_p), 64'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(2, 2), 32'h0, 4'h1);
    do_read("ch2_status_ack", mk(2, 0), 32'h0, 1'b0);
    check_output("db_level_ch2_low", 64'(db_l), 64'h0);

    apply_stimulus(1'b1, 1'b1, 1'b1, mk(1, 1), 32'h2, 4'h1);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(1, 3), 32'h1, 4'h1);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(1, 3), 32'h1, 4'h1);
    check_output("cm_pulse_ch1", 64'(cm_p), 64'h2);
    check_output("cm_level_ch1", 64'(cm_l), 64'h2);
    do_read("ch1_status_free", mk(1, 0), 32'h1, 1'b0);
    check_output("cm_pulse_ch1_single", 64'(cm_p), 64'h0);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(1, 3), 32'h0, 4'h1);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(1, 3), 32'h1, 4'h1);
    apply_stimulus(1'b1, 1'b0, 1'b0, 64'h0, 32'h0, 4'h0);
    check_output("cm_pulse_ch1_again", 64'(cm_p), 64'h2);

    do_read("oor_offset", mk(0, SHM + 4), 32'h0, 1'b1);
    do_read("ch0_status_err", mk(0, 0), 32'h3, 1'b0);
    apply_stimulus(1'b1, 1'b1, 1'b1, mk(0, 0), 32'h2, 4'h1);
    do_read("ch0_status_clr", mk(0, 0), 32'h1, 1'b0);

    apply_stimulus(1'b1, 1'b1, 1'b1, mk(3, 4), 32'hA5A5_A5A5, 4'b0101);
    do_read("payload_wstrb", mk(3, 4), 32'h00A5_00A5, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b1, mk(3, 5), 32'hFFFF_FFFF, 4'hF);
    do_read("payload_reset", mk(3, 4), 32'h0, 1'b0);
    do_read("payload_reset_wr", mk(3, 5), 32'h0, 1'b0);
    check_output("irqs_after_reset", 64'({db_l, cm_l, db_p, cm_p}), 64'h0);

    for (int i = 0; i < 65536; i++) apply_stimulus(1'b1, 1'b1, 1'b1, mk(0, 2), 32'h1, 4'h1);
    do_read("db_count_wrap", mk(0, 2), 32'h0000_0001, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      ch  = $urandom_range(0, NCH - 1);
      r   = $urandom_range(0, 9);
      off = (r < 6) ? $urandom_range(0, 3) : $urandom_range(4, SHM + 7);
      a   = mk(ch, off);
      if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} & 64'hFFFF_FFFF_FFFF_FC03);
      ws  = 4'($urandom) | 4'($urandom_range(0, 1));
      apply_stimulus(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1,
                     ($urandom_range(0, 9) != 0), 1'($urandom), a, $urandom, ws);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
